// File: rtl/png_pkg.sv
// png_pkg: shared definitions for the PNG chunk controller.
// Holds the word width, the chunk FSM state type and common PNG chunk type codes.
package png_pkg;

  localparam int unsigned DATA_WD = 32;
  // Word counter width: chunk length in whole 32-bit words.
  localparam int unsigned CNT_WD  = DATA_WD - 2;

  localparam logic [DATA_WD-1:0] TypIhdr = 32'h49484452;
  localparam logic [DATA_WD-1:0] TypIdat = 32'h49444154;
  localparam logic [DATA_WD-1:0] TypIend = 32'h49454E44;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StLen,
    StTyp,
    StDat,
    StWait,
    StCrc
  } state_e;

endpackage

// File: rtl/png_chunk_cnt.sv
// png_chunk_cnt: loadable word down-counter with is-last / is-zero flags.
// Saturates at zero so a stray decrement can never wrap.
module png_chunk_cnt import png_pkg::*; (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_i,
  input  logic [CNT_WD-1:0] load_val_i,
  input  logic              dec_i,
  output logic [CNT_WD-1:0] cnt_o,
  output logic              is_last_o,
  output logic              is_zero_o
);

  localparam logic [CNT_WD-1:0] CntOne = {{(CNT_WD-1){1'b0}}, 1'b1};

  logic [CNT_WD-1:0] r_cnt;

  // Count register: load has priority over decrement.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (dec_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CntOne;
    end
  end

  assign cnt_o     = r_cnt;
  assign is_last_o = (r_cnt == CntOne);
  assign is_zero_o = (r_cnt == '0);

endmodule

// File: rtl/png_chunk_ctrl.sv
// png_chunk_ctrl: sequences one PNG chunk as a word stream (length, type, data, CRC)
// and drives an external crc32 engine with the type and data words as they transfer.
// Optional feature: define PNG_CHUNK_CTRL_LEN_CHK_EN to check dat_lst_i against the
// word count and raise a sticky err_o; otherwise err_o is tied low.
module png_chunk_ctrl #(
  parameter int unsigned DATA_WD = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [DATA_WD-1:0] len_i,
  input  logic [DATA_WD-1:0] typ_i,
  input  logic               dat_val_i,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic               dat_lst_i,
  output logic               dat_rdy_o,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  output logic               lst_o,
  input  logic               rdy_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               crc_start_o,
  output logic               crc_val_o,
  output logic [DATA_WD-1:0] crc_dat_o,
  output logic               crc_lst_o,
  input  logic               crc_done_i,
  input  logic               crc_val_i,
  input  logic [DATA_WD-1:0] crc_dat_i
);
  import png_pkg::*;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [DATA_WD-1:0] r_typ;
  logic [DATA_WD-1:0] r_crc;
  logic               r_done;
  logic               w_accept;
  logic               w_xfer;
  logic               w_dat_xfer;
  logic               w_crc_hit;
  logic [CNT_WD-1:0]  w_cnt;
  logic               w_cnt_last;
  logic               w_cnt_zero;

  assign w_accept   = (r_state == StIdle) && start_i;
  assign w_xfer     = val_o && rdy_i;
  assign w_dat_xfer = (r_state == StDat) && w_xfer;
  assign w_crc_hit  = crc_val_i || crc_done_i;

  // The counter doubles as the latched length: it only moves during data.
  png_chunk_cnt u_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (w_accept),
    .load_val_i (len_i[DATA_WD-1:2]),
    .dec_i      (w_dat_xfer),
    .cnt_o      (w_cnt),
    .is_last_o  (w_cnt_last),
    .is_zero_o  (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (start_i) w_state_nxt = StInit;
      StInit: w_state_nxt = StLen;
      StLen:  if (w_xfer) w_state_nxt = StTyp;
      StTyp:  if (w_xfer) w_state_nxt = w_cnt_zero ? StWait : StDat;
      StDat:  if (w_xfer && w_cnt_last) w_state_nxt = StWait;
      StWait: if (w_crc_hit) w_state_nxt = StCrc;
      StCrc:  if (w_xfer) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output decode; the crc engine is fed only on the cycle a word leaves downstream.
  always_comb begin
    dat_rdy_o   = 1'b0;
    val_o       = 1'b0;
    dat_o       = '0;
    lst_o       = 1'b0;
    crc_start_o = 1'b0;
    crc_val_o   = 1'b0;
    crc_dat_o   = '0;
    crc_lst_o   = 1'b0;
    busy_o      = (r_state != StIdle);
    case (r_state)
      StInit: crc_start_o = 1'b1;
      StLen: begin
        val_o = 1'b1;
        dat_o = {w_cnt, 2'b00};
      end
      StTyp: begin
        val_o     = 1'b1;
        dat_o     = r_typ;
        crc_val_o = rdy_i;
        crc_dat_o = r_typ;
        crc_lst_o = rdy_i && w_cnt_zero;
      end
      StDat: begin
        dat_rdy_o = rdy_i;
        val_o     = dat_val_i;
        dat_o     = dat_i;
        crc_val_o = dat_val_i && rdy_i;
        crc_dat_o = dat_i;
        crc_lst_o = dat_val_i && rdy_i && w_cnt_last;
      end
      StCrc: begin
        val_o = 1'b1;
        dat_o = r_crc;
        lst_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Chunk datapath: type latch, CRC capture and the done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_typ  <= '0;
      r_crc  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == StCrc) && w_xfer;
      if (w_accept) begin
        r_typ <= typ_i;
      end
      if ((r_state == StWait) && w_crc_hit) begin
        r_crc <= crc_dat_i;
      end
    end
  end

  assign done_o = r_done;

`ifdef PNG_CHUNK_CTRL_LEN_CHK_EN
  logic r_err;
  logic w_unused;
  assign w_unused = ^len_i[1:0];

  // Sticky length error: dat_lst_i must coincide exactly with the counter's last word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_dat_xfer && (dat_lst_i != w_cnt_last)) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused;
  assign w_unused = ^{len_i[1:0], dat_lst_i};
  assign err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_png_chunk_ctrl.sv
// tb_png_chunk_ctrl: randomized bench for png_chunk_ctrl with a behavioural crc32 engine
// and a chunk-level reference model (expected word list and CRC computed from scratch).
module tb_png_chunk_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start_i, dat_val_i, dat_lst_i, rdy_i;
  logic [31:0] len_i, typ_i, dat_i;
  logic        dat_rdy_o, val_o, lst_o, busy_o, done_o, err_o;
  logic [31:0] dat_o, crc_dat_o;
  logic        crc_start_o, crc_val_o, crc_lst_o;
  logic        crc_done_i, crc_val_i;
  logic [31:0] crc_dat_i;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          done_cnt, start_cnt, viol;
  logic [32:0] obs[$];
  logic [31:0] eng_words[$];
  logic [31:0] eng_crc, eng_res;
  logic        eng_pend;
  logic [1:0]  eng_wait, eng_sel;
  logic [31:0] last_word;
  logic        last_err_exp;

  always #5 clk = ~clk;

  png_chunk_ctrl #(.DATA_WD(32)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i), .typ_i(typ_i),
    .dat_val_i(dat_val_i), .dat_i(dat_i), .dat_lst_i(dat_lst_i), .dat_rdy_o(dat_rdy_o),
    .val_o(val_o), .dat_o(dat_o), .lst_o(lst_o), .rdy_i(rdy_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .crc_start_o(crc_start_o), .crc_val_o(crc_val_o),
    .crc_dat_o(crc_dat_o), .crc_lst_o(crc_lst_o), .crc_done_i(crc_done_i),
    .crc_val_i(crc_val_i), .crc_dat_i(crc_dat_i)
  );

  // Reflected CRC-32 over the four bytes of a word, most significant byte first.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c;
    for (int b = 3; b >= 0; b--) begin
      r = r ^ {24'h0, w[8*b +: 8]};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // crc32 engine model: result appears 1..4 cycles after the last fed word.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eng_crc <= 32'hFFFFFFFF; eng_res <= '0; eng_pend <= 1'b0; eng_wait <= '0;
      crc_val_i <= 1'b0; crc_done_i <= 1'b0; crc_dat_i <= '0; eng_sel <= '0;
    end else begin
      eng_sel    <= 2'($urandom_range(0, 2));
      crc_val_i  <= 1'b0;
      crc_done_i <= 1'b0;
      if (crc_start_o) begin
        eng_crc <= 32'hFFFFFFFF;
      end else if (crc_val_o) begin
        eng_crc <= crc_upd(eng_crc, crc_dat_o);
        eng_words.push_back(crc_dat_o);
        if (crc_lst_o) begin
          eng_pend <= 1'b1;
          eng_wait <= 2'($urandom_range(0, 3));
          eng_res  <= ~crc_upd(eng_crc, crc_dat_o);
        end
      end
      if (eng_pend) begin
        if (eng_wait == 2'd0) begin
          eng_pend   <= 1'b0;
          crc_val_i  <= (eng_sel != 2'd2);
          crc_done_i <= (eng_sel != 2'd1);
          crc_dat_i  <= eng_res;
        end else begin
          eng_wait <= eng_wait - 2'd1;
        end
      end
    end
  end

  // Downstream monitor plus invariant counters.
  always @(negedge clk) begin
    if (rstn) begin
      if (val_o && rdy_i) obs.push_back({lst_o, dat_o});
      if (done_o) done_cnt <= done_cnt + 1;
      if (crc_start_o) start_cnt <= start_cnt + 1;
      if (crc_val_o && !(val_o && rdy_i)) viol <= viol + 1;
      if (dat_rdy_o && !busy_o) viol <= viol + 1;
    end
  end

  task automatic run_chunk(input string name, input int nwords, input logic [31:0] typ,
                           input int rdy_mode, input int lst_at, input bit mid_start,
                           input bit use_w0, input logic [31:0] w0);
    logic [31:0] data[$];
    logic [32:0] exp[$];
    logic [31:0] c;
    logic        err_exp;
    int          idx, cyc, stall;
    bit          stalled;
    data.delete(); exp.delete();
    for (int i = 0; i < nwords; i++) data.push_back((i == 0 && use_w0) ? w0 : $urandom);
    c = crc_upd(32'hFFFFFFFF, typ);
    foreach (data[i]) c = crc_upd(c, data[i]);
    exp.push_back({1'b0, nwords[29:0], 2'b00});
    exp.push_back({1'b0, typ});
    foreach (data[i]) exp.push_back({1'b0, data[i]});
    exp.push_back({1'b1, ~c});
    err_exp = 1'b0;
`ifdef PNG_CHUNK_CTRL_LEN_CHK_EN
    for (int i = 0; i < nwords; i++) if ((i == lst_at) != (i == nwords - 1)) err_exp = 1'b1;
`endif
    obs.delete(); eng_words.delete();
    done_cnt = 0; start_cnt = 0; viol = 0;
    @(posedge clk); #1;
    start_i = 1'b1; len_i = {nwords[29:0], 2'b00} | 32'($urandom_range(0, 3)); typ_i = typ;
    @(posedge clk); #1;
    start_i = 1'b0; len_i = $urandom; typ_i = $urandom;
    check_eq({name, "_init_start"}, {62'h0, busy_o, crc_start_o}, 64'h3);
    check_eq({name, "_err_clr"}, err_o, 0);
    idx = 0; cyc = 0; stall = 0; stalled = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      if (rdy_mode == 2 && idx == 2 && !stalled) begin stall = 3; stalled = 1; end
      case (rdy_mode)
        0:       rdy_i = 1'b1;
        1:       rdy_i = ($urandom_range(0, 2) != 0);
        default: rdy_i = (stall == 0);
      endcase
      if (idx < nwords) begin
        dat_val_i = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        dat_i     = data[idx];
        dat_lst_i = (idx == lst_at);
      end else begin
        dat_val_i = 1'b0; dat_i = $urandom; dat_lst_i = 1'($urandom_range(0, 1));
      end
      if (mid_start && cyc == 4) begin
        start_i = 1'b1; len_i = $urandom; typ_i = $urandom;
      end
      @(negedge clk);
      if (start_i) check_eq({name, "_busy_restart"}, busy_o, 1);
      if (stall > 0) begin check_eq({name, "_stall_rdy"}, dat_rdy_o, 0); stall--; end
      if (dat_val_i && dat_rdy_o) idx++;
      @(posedge clk); #1;
      start_i = 1'b0;
      cyc++;
    end
    check_eq({name, "_finished"}, (done_cnt != 0), 1);
    dat_val_i = 1'b0; rdy_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq({name, "_nwords"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      check_eq($sformatf("%s_w%0d", name, i), obs[i], exp[i]);
    check_eq({name, "_crc_feeds"}, eng_words.size(), nwords + 1);
    for (int i = 0; i < eng_words.size() && i < nwords + 1; i++)
      check_eq($sformatf("%s_feed%0d", name, i), eng_words[i], exp[i+1][31:0]);
    check_eq({name, "_done_pulses"}, done_cnt, 1);
    check_eq({name, "_crc_starts"}, start_cnt, 1);
    check_eq({name, "_idle"}, busy_o, 0);
    check_eq({name, "_err"}, err_o, err_exp);
    check_eq({name, "_invariants"}, viol, 0);
    last_word    = (obs.size() != 0) ? obs[obs.size()-1][31:0] : 32'h0;
    last_err_exp = err_exp;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {dat_rdy_o, val_o, lst_o, busy_o, done_o, err_o,
                             crc_start_o, crc_val_o, crc_lst_o}, 0);
    check_eq({tag, "_dat"}, {dat_o, crc_dat_o}, 0);
  endtask

  task automatic reset_in_dat();
    int cyc;
    @(posedge clk); #1;
    start_i = 1'b1; len_i = 32'd16; typ_i = 32'h49444154; rdy_i = 1'b1; dat_val_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    while (!dat_rdy_o && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check_eq("rst_reached_dat", dat_rdy_o, 1);
    dat_val_i = 1'b1; dat_i = $urandom;
    #1 rstn = 1'b0;
    #1 check_all_zero("rst_mid_dat");
    dat_val_i = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; start_i = 1'b0; len_i = '0; typ_i = '0; dat_val_i = 1'b0; dat_i = '0;
    dat_lst_i = 1'b0; rdy_i = 1'b1;
    done_cnt = 0; start_cnt = 0; viol = 0;
    #3 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    check_eq("post_reset_busy", busy_o, 0);

    run_chunk("iend", 0, 32'h49454E44, 0, -1, 0, 0, 32'h0);
    check_eq("iend_crc_const", last_word, 32'hAE426082);
    run_chunk("len4", 1, 32'h49444154, 0, 0, 0, 1, 32'h04090409);
    run_chunk("stall16", 4, 32'h49444154, 2, 3, 0, 0, 32'h0);
    run_chunk("midstart", 8, 32'h49484452, 0, 7, 1, 0, 32'h0);
    reset_in_dat();
    run_chunk("iend_after_rst", 0, 32'h49454E44, 1, -1, 0, 0, 32'h0);
    check_eq("iend_after_rst_crc", last_word, 32'hAE426082);
    run_chunk("early_lst", 2, 32'h49444154, 0, 0, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1 check_eq("err_sticky", err_o, last_err_exp);
    for (int n = 0; n < 8; n++) begin
      int nw;
      nw = $urandom_range(0, 6);
      run_chunk($sformatf("rand%0d", n), nw, $urandom, 1,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : nw - 1, 0, 0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/png_chunk_ctrl.md
PNG_CHUNK_CTRL -- requirements
Module: png_chunk_ctrl

Interface
REQ-001 Parameter DATA_WD, default 32: width of all data words; only 32 is supported.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rstn  in  1  asynchronous active-low reset.
REQ-004 start_i  in  1  one-cycle pulse; begins one chunk; ignored while busy_o=1.
REQ-005 len_i  in  32  chunk data length in bytes, sampled at start_i; bits [1:0] ignored (whole words only).
REQ-006 typ_i  in  32  chunk type (e.g. 32'h49454E44 "IEND"), sampled at start_i.
REQ-007 dat_val_i / dat_i / dat_lst_i  in  1/32/1  upstream data word stream; dat_lst_i marks the final word.
REQ-008 dat_rdy_o  out  1  upstream ready; a word transfers when dat_val_i & dat_rdy_o.
REQ-009 val_o / dat_o / lst_o  out  1/32/1  chunk word stream: length, type, data..., CRC; lst_o is set on the CRC word.
REQ-010 rdy_i  in  1  downstream ready; a word transfers when val_o & rdy_i.
REQ-011 busy_o / done_o / err_o  out  1  busy flag; one-cycle done pulse after the CRC word transfers; length-error flag.
REQ-012 crc_start_o / crc_val_o / crc_dat_o / crc_lst_o  out  1/1/32/1  drive the crc32 engine (start/val/dat/lst).
REQ-013 crc_done_i / crc_val_i / crc_dat_i  in  1/1/32  crc32 engine result; the CRC is captured when crc_val_i=1.

Function
REQ-014 FSM states: IDLE, INIT, LEN, TYP, DAT, WAIT, CRC.
REQ-015 IDLE -> INIT on start_i; INIT asserts crc_start_o for exactly 1 cycle, then -> LEN.
REQ-016 LEN: val_o=1, dat_o={len_i[31:2],2'b00}; this word is not fed to the CRC; -> TYP on transfer.
REQ-017 TYP: val_o=1, dat_o=typ_i; on transfer, crc_val_o=1 and crc_dat_o=typ_i in the same cycle; crc_lst_o=1 if the word count is 0; -> DAT, or -> WAIT if the word count is 0.
REQ-018 DAT: dat_rdy_o=rdy_i and val_o=dat_val_i, combinationally; each transfer feeds crc_val_o/crc_dat_o in the same cycle and decrements the word counter; crc_lst_o is set on the final word; -> WAIT after the final word.
REQ-019 WAIT: val_o=0; hold until crc_val_i, latch crc_dat_i, -> CRC; crc_done_i is accepted as an equivalent terminator.
REQ-020 CRC: val_o=1, dat_o=latched CRC, lst_o=1; on transfer, done_o pulses for 1 cycle, -> IDLE.
REQ-021 The crc32 engine is never fed unless a downstream transfer occurs; there are no duplicated or dropped words under any rdy_i pattern.
REQ-022 Word counter is 30 bits, loaded with len_i[31:2]; no wrap (it saturates at 0).
REQ-023 dat_rdy_o=0 in all states except DAT.
REQ-024 busy_o=1 in all states except IDLE; start_i while busy_o=1 has no effect.

Reset
REQ-025 rstn low forces IDLE asynchronously: all outputs 0, counter 0, latched CRC 0, err_o 0.
REQ-026 Reset mid-chunk abandons the chunk; there is no partial done_o; the next start_i restarts cleanly.

Configuration
REQ-027 Macro PNG_CHUNK_CTRL_LEN_CHK_EN defined: dat_lst_i is compared against the counter.
- dat_lst_i before the last word, or its absence on the last word, sets err_o.
- err_o is sticky until the next accepted start_i.
- The chunk still terminates by the counter.
REQ-028 Macro undefined: dat_lst_i is ignored and err_o is tied to 0.

Structure
REQ-029 Shared package png_pkg holds:
- FSM state enum;
- DATA_WD;
- PNG chunk type constants (IHDR, IDAT, IEND).
REQ-030 Sub-module png_chunk_cnt: loadable down-counter with is-last flag; the crc32 engine is instantiated outside this block.

Verification
REQ-031 IEND: start_i, len_i=0, typ_i=32'h49454E44, rdy_i=1 -> stream 00000000, 49454E44, AE426082 (lst_o=1), then done_o.
REQ-032 len_i=4, data 32'h04090409 -> 00000004, type, 04090409, CRC equal to the golden model; crc32 receives exactly 2 words.
REQ-033 len_i=16 with rdy_i low for 3 cycles mid-data -> dat_rdy_o=0 during the stall; 4 data words, no duplicates; CRC matches the model.
REQ-034 start_i pulsed during DAT -> ignored; the current chunk completes unchanged.
REQ-035 rstn asserted in DAT -> all outputs 0 immediately; a new IEND chunk afterwards is correct (per REQ-031).
REQ-036 With LEN_CHK_EN, len_i=8 and dat_lst_i on the 1st word -> err_o=1 until the next start_i; the chunk still emits 2 data words.
